mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single-port RAM between instruction fetch (iREN/iaddr) and data access (dREN/dWEN/daddr).
//  The data requests come from the memtoReg/memWr decode.
//  Sits between the datapath request unit and ram_if.
//  Grants one requester at a time, holds the grant until the RAM completes, and returns data with wait handshakes.
//  Data has priority; a streak limit guarantees instruction fetch progress. RAM ERROR responses are retried.
// PARAMETERS
//  MAX_DSTREAK  4  consecutive data grants allowed while iREN pending before an I-grant is forced (>=1)
//  RETRY_MAX    3  ERROR responses tolerated per access; the next ERROR sets err
// PORTS
//  CLK        in   1   clock, rising edge
//  RST        in   1   synchronous reset, active-high
//  halt       in   1   processor halted; no new instruction grants
//  iREN       in   1   instruction read request
//  iaddr      in   32  instruction word address
//  iload      out  32  instruction data; valid while iwait==0
//  iwait      out  1   0 = instruction access completes this cycle
//  dREN       in   1   data read request
//  dWEN       in   1   data write request; dREN&dWEN together is treated as a write
//  daddr      in   32  data address
//  dstore     in   32  write data
//  dload      out  32  read data; valid while dwait==0
//  dwait      out  1   0 = data access completes this cycle
//  ramREN     out  1   RAM read enable
//  ramWEN     out  1   RAM write enable
//  ramaddr    out  32  RAM address
//  ramstore   out  32  RAM write data
//  ramload    in   32  RAM read data
//  ramstate   in   2   ramstate_t: FREE, BUSY, ACCESS, ERROR
//  err        out  1   sticky; retry limit exceeded
// BEHAVIOUR
//  FSM states IDLE, IGRANT, DGRANT. Registered: state, dstreak (3b sat), retries (2b), err.
//  Reset (RST=1 at edge): state=IDLE, dstreak=0, retries=0, err=0.
//  - IDLE: ramREN=ramWEN=0, ramaddr=0, ramstore=0, iwait=dwait=1, iload=dload=0.
//  IDLE next state:
//  - IGRANT if iREN & !halt & (!(dREN|dWEN) | dstreak>=MAX_DSTREAK).
//  - Else DGRANT if dREN|dWEN.
//  - Else stay IDLE.
//  IGRANT: ramREN=1, ramaddr=iaddr.
//  DGRANT: ramaddr=daddr. Write: ramWEN=1, ramstore=dstore. Otherwise ramREN=1.
//  RAM outputs are combinational from state and the live request inputs.
//  Completion (ramstate==ACCESS in a grant state):
//  - That requester's wait=0 and its load=ramload for that cycle only.
//  - Next state=IDLE, retries cleared.
//  - The other wait stays 1 in all cycles except its own completion.
//  Latency: >=1 arbitration cycle (IDLE) + RAM latency. Back-to-back accesses always pass through IDLE.
//  dstreak:
//  - +1 (saturating) on each data completion while iREN=1.
//  - Cleared on instruction completion, or on any cycle with iREN=0.
//  ERROR in a grant state: retries+1 and stay granted, i.e. the access is re-driven.
//  - If retries==RETRY_MAX, set err=1, give completion (wait=0, load=ramload), reset retries, go to IDLE.
//  - err clears only on RST.
//  BUSY/FREE in a grant state: hold grant, wait=1.
//  Request dropped mid-grant (granted REN/WEN falls):
//  - Drive ram enables 0 that cycle, no completion pulse.
//  - Next state=IDLE, retries cleared.
//  halt=1 during IGRANT: current fetch finishes normally; no new IGRANT while halt=1. Data grants continue.
//  RST mid-access: abandon immediately; outputs take reset values the next cycle.
// TESTING
//  iREN=1 iaddr=0x40, RAM BUSY 2 cycles then ACCESS ramload=0xDEADBEEF -> ramREN=1 for 3 cycles, iwait=0 and iload=0xDEADBEEF in the 3rd.
//  iREN=1 and dWEN=1 daddr=0x80 dstore=0x5 same cycle -> DGRANT first with ramWEN=1; IGRANT follows after one IDLE cycle.
//  iREN held plus continuous dREN, RAM always ACCESS -> exactly 4 data completions, then 1 instruction completion, repeating.
//  Grant with ERROR x3 then ACCESS -> 3 re-drives, err=0 on completion; ERROR x4 -> completion on 4th ERROR with err=1 sticky.
//  dREN dropped during BUSY -> no dwait pulse, IDLE next cycle; RST during BUSY -> ramREN=0, iwait=dwait=1 next cycle.
//  halt=1 with iREN=1 -> no IGRANT; dREN=1 still served.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data access.
// Data requests win arbitration, but a streak counter forces an instruction grant
// after MAX_DSTREAK consecutive data completions while a fetch is waiting.
// RAM ERROR responses re-drive the access up to RETRY_MAX times before flagging err.
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned RETRY_MAX   = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  localparam int unsigned STREAK_W = 3;
  localparam int unsigned RETRY_W  = 2;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGRANT = 2'd1;
  localparam logic [1:0] DGRANT = 2'd2;

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(MAX_DSTREAK);
  localparam logic [STREAK_W-1:0] STREAK_SAT   = '1;
  localparam logic [RETRY_W-1:0]  RETRY_LIMIT  = RETRY_W'(RETRY_MAX);

  logic [1:0]          state, state_next;
  logic [STREAK_W-1:0] dstreak, dstreak_next;
  logic [RETRY_W-1:0]  retries, retries_next;
  logic                err_next;
  logic                d_req;
  logic                req_live;
  logic                done;

  // A write wins when both dREN and dWEN are raised
  assign d_req = dREN | dWEN;

  // State and bookkeeping registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      dstreak <= '0;
      retries <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_next;
      dstreak <= dstreak_next;
      retries <= retries_next;
      err     <= err_next;
    end
  end

  // Arbitration, RAM drive, completion, retry and streak next-state logic
  always_comb begin
    state_next   = state;
    dstreak_next = dstreak;
    retries_next = retries;
    err_next     = err;
    ramREN       = 1'b0;
    ramWEN       = 1'b0;
    ramaddr      = '0;
    ramstore     = '0;
    iwait        = 1'b1;
    dwait        = 1'b1;
    iload        = '0;
    dload        = '0;
    req_live     = 1'b0;
    done         = 1'b0;

    case (state)
      IDLE: begin
        if (iREN && !halt && (!d_req || dstreak >= STREAK_LIMIT)) begin
          state_next = IGRANT;
        end else if (d_req) begin
          state_next = DGRANT;
        end
      end
      IGRANT: begin
        req_live = iREN;
        ramaddr  = iaddr;
        ramREN   = iREN;
      end
      DGRANT: begin
        req_live = d_req;
        ramaddr  = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = dREN;
        end
      end
      default: state_next = IDLE;
    endcase

    // Grant states: a dropped request abandons the access without completion
    if (state == IGRANT || state == DGRANT) begin
      if (!req_live) begin
        state_next   = IDLE;
        retries_next = '0;
      end else begin
        case (ramstate)
          RAM_ACCESS: done = 1'b1;
          RAM_ERROR: begin
            if (retries == RETRY_LIMIT) begin
              err_next = 1'b1;
              done     = 1'b1;
            end else begin
              retries_next = retries + RETRY_W'(1);
            end
          end
          RAM_FREE, RAM_BUSY: ;
        endcase
      end

      if (done) begin
        state_next   = IDLE;
        retries_next = '0;
        if (state == IGRANT) begin
          iwait = 1'b0;
          iload = ramload;
        end else begin
          dwait = 1'b0;
          dload = ramload;
        end
      end
    end

    // Streak counts data completions only while a fetch is pending
    if (!iREN) begin
      dstreak_next = '0;
    end else if (done && state == IGRANT) begin
      dstreak_next = '0;
    end else if (done && state == DGRANT && dstreak != STREAK_SAT) begin
      dstreak_next = dstreak + STREAK_W'(1);
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; completions are checked in order against a scoreboard queue.
module tb_mem_arbiter;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        iwait;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dwait;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected completions: bit 32 = instruction side, bits 31:0 = load data
  logic [32:0] exp_q[$];

  mem_arbiter dut (
    .CLK(CLK), .RST(RST), .halt(halt),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic nxt;
    @(posedge CLK);
    #1;
  endtask

  task automatic mid;
    @(negedge CLK);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_i(input logic [31:0] data);
    exp_q.push_back({1'b1, data});
  endtask

  task automatic push_d(input logic [31:0] data);
    exp_q.push_back({1'b0, data});
  endtask

  // Monitor: every completion pulse must match the next scoreboard entry
  always @(negedge CLK) begin
    logic [32:0] got;
    logic [32:0] want;
    if (!iwait || !dwait) begin
      got = {!iwait, (!iwait ? iload : dload)};
      n_cmp++;
      if (!iwait && !dwait) begin
        n_bad++;
        $display("FAIL both_wait_low: iwait=%b dwait=%b required one side only (t=%0t)", iwait, dwait, $time);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_completion: got side=%b data=%h required none (t=%0t)", got[32], got[31:0], $time);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_bad++;
          $display("FAIL completion: got side=%b data=%h required side=%b data=%h (t=%0t)",
                   got[32], got[31:0], want[32], want[31:0], $time);
        end
      end
    end
  end

  initial begin
    RST = 1'b1; halt = 1'b0; iREN = 1'b0; iaddr = '0; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;

    // Reset state
    nxt; nxt;
    mid;
    chk("rst_ramREN", 32'(ramREN), 32'd0);
    chk("rst_iwait", 32'(iwait), 32'd1);
    chk("rst_dwait", 32'(dwait), 32'd1);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_ramaddr", ramaddr, 32'd0);
    nxt; RST = 1'b0;

    // Instruction fetch, two BUSY cycles then ACCESS
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY;
    mid; chk("t1_arb_ramREN", 32'(ramREN), 32'd0);
    nxt; mid; chk("t1_c1_ramREN", 32'(ramREN), 32'd1); chk("t1_c1_ramaddr", ramaddr, 32'h40);
    nxt; mid; chk("t1_c2_ramREN", 32'(ramREN), 32'd1); chk("t1_c2_iwait", 32'(iwait), 32'd1);
    nxt; ramstate = RS_ACCESS; ramload = 32'hDEADBEEF; push_i(32'hDEADBEEF);
    mid; chk("t1_c3_ramREN", 32'(ramREN), 32'd1);
    nxt; iREN = 1'b0; ramstate = RS_FREE;
    mid; chk("t1_after_ramREN", 32'(ramREN), 32'd0);

    // Simultaneous fetch and write: data first, then fetch after one IDLE
    nxt;
    iREN = 1'b1; dWEN = 1'b1; daddr = 32'h80; dstore = 32'h5; ramstate = RS_ACCESS; ramload = 32'h11;
    mid; chk("t2_arb_ramWEN", 32'(ramWEN), 32'd0);
    nxt; push_d(32'h11);
    mid; chk("t2_ramWEN", 32'(ramWEN), 32'd1); chk("t2_ramREN", 32'(ramREN), 32'd0);
    chk("t2_ramaddr", ramaddr, 32'h80); chk("t2_ramstore", ramstore, 32'h5);
    nxt; dWEN = 1'b0;
    mid; chk("t2_idle_ramREN", 32'(ramREN), 32'd0); chk("t2_idle_ramWEN", 32'(ramWEN), 32'd0);
    nxt; push_i(32'h11);
    mid; chk("t2_ig_ramREN", 32'(ramREN), 32'd1); chk("t2_ig_ramaddr", ramaddr, 32'h40);
    nxt; iREN = 1'b0; ramstate = RS_FREE;
    mid;

    // Streak limit: four data completions then one fetch, twice
    nxt;
    iREN = 1'b1; dREN = 1'b1; daddr = 32'h90; ramstate = RS_ACCESS; ramload = 32'h22;
    for (int k = 0; k < 10; k++) begin
      if ((k % 5) == 4) push_i(32'h22);
      else push_d(32'h22);
    end
    repeat (20) nxt;
    iREN = 1'b0; dREN = 1'b0; ramstate = RS_FREE;
    mid; chk("t3_end_ramREN", 32'(ramREN), 32'd0);
    chk("t3_queue_drained", 32'(exp_q.size()), 32'd0);

    // Three ERRORs then ACCESS: re-driven, completes without err
    nxt;
    dREN = 1'b1; daddr = 32'h100; ramstate = RS_ERROR; ramload = 32'h33;
    mid;
    for (int k = 0; k < 3; k++) begin
      nxt; mid;
      chk("t4a_redrive_ramREN", 32'(ramREN), 32'd1);
      chk("t4a_redrive_dwait", 32'(dwait), 32'd1);
    end
    nxt; ramstate = RS_ACCESS; push_d(32'h33);
    mid; chk("t4a_err_during", 32'(err), 32'd0);
    nxt; dREN = 1'b0; ramstate = RS_FREE;
    mid; chk("t4a_err_after", 32'(err), 32'd0);

    // Four ERRORs: completion on the fourth with err set
    nxt;
    dREN = 1'b1; ramstate = RS_ERROR; ramload = 32'h44;
    mid;
    for (int k = 0; k < 3; k++) begin
      nxt; mid; chk("t4b_redrive_ramREN", 32'(ramREN), 32'd1);
    end
    nxt; push_d(32'h44);
    mid; chk("t4b_err_not_yet", 32'(err), 32'd0);
    nxt; dREN = 1'b0; ramstate = RS_FREE;
    mid; chk("t4b_err_set", 32'(err), 32'd1);

    // Data request dropped during BUSY: no completion, back through IDLE
    nxt;
    dREN = 1'b1; daddr = 32'h180; ramstate = RS_BUSY;
    mid;
    nxt; mid; chk("t5_busy1_ramREN", 32'(ramREN), 32'd1);
    nxt; mid; chk("t5_busy2_ramREN", 32'(ramREN), 32'd1);
    nxt; dREN = 1'b0;
    mid; chk("t5_drop_ramREN", 32'(ramREN), 32'd0); chk("t5_drop_dwait", 32'(dwait), 32'd1);
    nxt; dREN = 1'b1; ramstate = RS_ACCESS; ramload = 32'h66;
    mid; chk("t5_idle_ramREN", 32'(ramREN), 32'd0);
    nxt; push_d(32'h66);
    mid; chk("t5_err_sticky", 32'(err), 32'd1);
    nxt; dREN = 1'b0; ramstate = RS_FREE;

    // Reset in the middle of a BUSY fetch
    iREN = 1'b1; iaddr = 32'h40; ramstate = RS_BUSY;
    mid;
    nxt; mid; chk("t6_busy_ramREN", 32'(ramREN), 32'd1);
    nxt; RST = 1'b1;
    mid; chk("t6_rst_edge_pending", 32'(ramREN), 32'd1);
    nxt; mid;
    chk("t6_rst_ramREN", 32'(ramREN), 32'd0);
    chk("t6_rst_iwait", 32'(iwait), 32'd1);
    chk("t6_rst_dwait", 32'(dwait), 32'd1);
    chk("t6_rst_err", 32'(err), 32'd0);
    nxt; RST = 1'b0; iREN = 1'b0; ramstate = RS_FREE;

    // halt blocks new fetch grants but data is still served
    halt = 1'b1; iREN = 1'b1; iaddr = 32'h40; ramstate = RS_ACCESS; ramload = 32'h55;
    for (int k = 0; k < 3; k++) begin
      mid; chk("t7_halt_ramREN", 32'(ramREN), 32'd0);
      nxt;
    end
    dREN = 1'b1; daddr = 32'h200;
    mid; chk("t7_arb_ramREN", 32'(ramREN), 32'd0);
    nxt; push_d(32'h55);
    mid; chk("t7_d_ramREN", 32'(ramREN), 32'd1); chk("t7_d_ramaddr", ramaddr, 32'h200);
    nxt; dREN = 1'b0;
    mid; chk("t7_post_d_ramREN", 32'(ramREN), 32'd0);
    nxt; mid; chk("t7_still_halted", 32'(ramREN), 32'd0);
    nxt; halt = 1'b0;
    mid; chk("t7_release_arb", 32'(ramREN), 32'd0);
    nxt; push_i(32'h55);
    mid; chk("t7_i_ramaddr", ramaddr, 32'h40);
    nxt; iREN = 1'b0; ramstate = RS_FREE;
    mid;
    nxt;

    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
